// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: digit-code inputs and multiplexed display outputs
// of the 7-segment scan driver, bundled for the datapath/display boundary.
//
// Signalling: dig5..dig1 are plain level codes with no valid/ready
// handshake. The driver samples them only at the frame wrap, so the
// producer may change them at any time. frame_start is a one-cycle pulse
// marking the cycle in which the sample was taken.
interface seg7_scan_driver_if;
    logic [3:0] dig5;
    logic [3:0] dig4;
    logic [3:0] dig3;
    logic [3:0] dig2;
    logic [3:0] dig1;
    logic [6:0] seg;
    logic [4:0] an;
    logic       frame_start;

    // Producer of digit codes; observer of display outputs
    modport master (
        output dig5, dig4, dig3, dig2, dig1,
        input  seg, an, frame_start
    );

    // The scan driver itself
    modport slave (
        input  dig5, dig4, dig3, dig2, dig1,
        output seg, an, frame_start
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexes five digit codes onto a 5-digit 7-segment
// display, one digit lit at a time for REFRESH_DIV cycles each.
// Codes 0-9 show numerals, 11 shows a minus sign, everything else is blank.
// Digit codes are captured once per scan frame so a frame never mixes old
// and new values. an/seg are registered (one cycle behind idx/shadow).
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros in
// positions dig4..dig2 at snapshot time (dig1 and dig5 are never altered).
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 50000,  // cycles per lit digit, 2..2^20
    parameter bit SEG_ACT_LOW = 1'b1    // 1: active-low seg/an outputs
) (
    input  logic               clk,
    input  logic               rst,
    seg7_scan_driver_if.slave  bus
);

    localparam int            CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(REFRESH_DIV - 1);
    localparam logic [6:0]    SEG_INV  = SEG_ACT_LOW ? 7'h7f : 7'h00;
    localparam logic [4:0]    AN_INV   = SEG_ACT_LOW ? 5'h1f : 5'h00;
    localparam logic [3:0]    CODE_BLK = 4'd10;

    logic [CW-1:0]    cnt;
    logic [2:0]       idx;
    logic [4:0][3:0]  shadow;   // [0] = rightmost digit
    logic [4:0][3:0]  snap;     // codes to be captured at the next wrap
    logic             tick;
    logic             wrap;
    logic [3:0]       cur_code;
    logic [6:0]       seg_hi;
    logic [4:0]       an_hi;
`ifdef LEADING_ZERO_BLANK_EN
    logic             lead;
`endif

    // Active-high segment pattern {g,f,e,d,c,b,a} for a digit code
    function automatic logic [6:0] seg_map(input logic [3:0] code);
        case (code)
            4'd0:    seg_map = 7'b0111111;
            4'd1:    seg_map = 7'b0000110;
            4'd2:    seg_map = 7'b1011011;
            4'd3:    seg_map = 7'b1001111;
            4'd4:    seg_map = 7'b1100110;
            4'd5:    seg_map = 7'b1101101;
            4'd6:    seg_map = 7'b1111101;
            4'd7:    seg_map = 7'b0000111;
            4'd8:    seg_map = 7'b1111111;
            4'd9:    seg_map = 7'b1101111;
            4'd11:   seg_map = 7'b1000000;
            default: seg_map = 7'b0000000;
        endcase
    endfunction

    // Refresh tick and end-of-frame detection
    always_comb begin
        tick = (cnt == CNT_MAX);
        wrap = tick && (idx == 3'd4);
    end

    // Codes to capture at the frame wrap, with optional leading-zero blanking
    always_comb begin
        snap = {bus.dig5, bus.dig4, bus.dig3, bus.dig2, bus.dig1};
`ifdef LEADING_ZERO_BLANK_EN
        // Walk from dig4 toward dig2; blanks and zeros keep the run going,
        // the first other code (including minus) ends it.
        lead = 1'b1;
        for (int p = 3; p >= 1; p--) begin
            if (lead) begin
                if (snap[p] == 4'd0) begin
                    snap[p] = CODE_BLK;
                end else if (snap[p] != CODE_BLK) begin
                    lead = 1'b0;
                end
            end
        end
`endif
    end

    // Select the code of the digit currently being scanned
    always_comb begin
        case (idx)
            3'd0:    cur_code = shadow[0];
            3'd1:    cur_code = shadow[1];
            3'd2:    cur_code = shadow[2];
            3'd3:    cur_code = shadow[3];
            3'd4:    cur_code = shadow[4];
            default: cur_code = CODE_BLK;
        endcase
        seg_hi = seg_map(cur_code);
        an_hi  = 5'b00001 << idx;
    end

    // Divider, scan index, frame snapshot and registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt             <= '0;
            idx             <= 3'd0;
            shadow          <= {5{CODE_BLK}};
            bus.frame_start <= 1'b0;
            bus.seg         <= SEG_INV;
            bus.an          <= AN_INV;
        end else begin
            bus.seg         <= seg_hi ^ SEG_INV;
            bus.an          <= an_hi ^ AN_INV;
            bus.frame_start <= wrap;
            if (tick) begin
                cnt <= '0;
                idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (wrap) begin
                shadow <= snap;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of the scan driver with
// REFRESH_DIV=4 and active-low outputs. Expected patterns are hand-entered
// active-high segment codes per scan position.
module tb_seg7_scan_driver;

    localparam int REFRESH_DIV = 4;

    // Active-high segment patterns {g..a}
    localparam logic [6:0] P0  = 7'b0111111;
    localparam logic [6:0] P1  = 7'b0000110;
    localparam logic [6:0] P2  = 7'b1011011;
    localparam logic [6:0] P3  = 7'b1001111;
    localparam logic [6:0] P4  = 7'b1100110;
    localparam logic [6:0] P5  = 7'b1101101;
    localparam logic [6:0] P6  = 7'b1111101;
    localparam logic [6:0] P7  = 7'b0000111;
    localparam logic [6:0] P8  = 7'b1111111;
    localparam logic [6:0] P9  = 7'b1101111;
    localparam logic [6:0] PMN = 7'b1000000;
    localparam logic [6:0] PBL = 7'b0000000;

    typedef struct {
        logic [3:0]      d5, d4, d3, d2, d1;
        logic [4:0][6:0] exp;   // active-high pattern per scan position, [0]=dig1
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    vec_t vecs[5];
    logic [11:0] exp_q[$];

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(
        .REFRESH_DIV (REFRESH_DIV),
        .SEG_ACT_LOW (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_digits(input logic [3:0] d5, d4, d3, d2, d1);
        bus.dig5 = d5;
        bus.dig4 = d4;
        bus.dig3 = d3;
        bus.dig2 = d2;
        bus.dig1 = d1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance until frame_start is seen; bounded
    task automatic wait_frame();
        for (int i = 0; i < 60; i++) begin
            step();
            if (bus.frame_start) return;
        end
        chk("frame_start_timeout", 32'd0, 32'd1);
    endtask

    // Outputs held inactive while in reset
    task automatic chk_inactive(input string tag);
        chk({tag, "_an"}, {27'd0, bus.an}, 32'h1f);
        chk({tag, "_seg"}, {25'd0, bus.seg}, 32'h7f);
        chk({tag, "_fs"}, {31'd0, bus.frame_start}, 32'd0);
    endtask

    // Called at the negedge just after rst is dropped: first frame is all
    // blank with the one-hot enable rotating, and frame_start on cycle 20.
    task automatic chk_startup();
        for (int k = 0; k < 20; k++) begin
            step();
            chk("start_an", {27'd0, bus.an}, {27'd0, ~(5'b00001 << (k / 4))});
            chk("start_seg", {25'd0, bus.seg}, 32'h7f);
            chk("start_fs", {31'd0, bus.frame_start}, {31'd0, (k == 19)});
        end
    endtask

    // Called at the negedge where frame_start was just seen: checks the 20
    // cycles of the following frame. Optionally changes dig1 after cycle
    // poke_k to show the running frame is unaffected.
    task automatic chk_frame(input logic [4:0][6:0] e, input int poke_k, input logic [3:0] poke_val);
        logic [11:0] exp_w;
        for (int k = 0; k < 20; k++) begin
            exp_q.push_back({~(5'b00001 << (k / 4)), ~e[k / 4]});
        end
        for (int k = 0; k < 20; k++) begin
            step();
            exp_w = exp_q.pop_front();
            chk("frame_an", {27'd0, bus.an}, {27'd0, exp_w[11:7]});
            chk("frame_seg", {25'd0, bus.seg}, {25'd0, exp_w[6:0]});
            chk("frame_fs", {31'd0, bus.frame_start}, {31'd0, (k == 19)});
            if (k == poke_k) bus.dig1 = poke_val;
        end
    endtask

    initial begin
        logic [4:0][6:0] e;
        checks   = 0;
        failures = 0;

        // Vector table: {dig5..dig1, expected patterns {pos4..pos0}}
        vecs[0] = '{4'd10, 4'd0, 4'd1, 4'd2, 4'd3, {PBL, P0, P1, P2, P3}};
        vecs[1] = '{4'd11, 4'd0, 4'd0, 4'd0, 4'd0, {PMN, P0, P0, P0, P0}};
        vecs[2] = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd8, {P4, P5, P6, P7, P8}};
        vecs[3] = '{4'd9, 4'd12, 4'd13, 4'd14, 4'd15, {P9, PBL, PBL, PBL, PBL}};
        vecs[4] = '{4'd10, 4'd0, 4'd0, 4'd5, 4'd0, {PBL, P0, P0, P5, P0}};
`ifdef LEADING_ZERO_BLANK_EN
        vecs[0].exp = {PBL, PBL, P1, P2, P3};
        vecs[1].exp = {PMN, PBL, PBL, PBL, P0};
        vecs[4].exp = {PBL, PBL, PBL, P5, P0};
`endif

        // Reset held 3 cycles
        rst = 1'b1;
        set_digits(4'd10, 4'd0, 4'd1, 4'd2, 4'd3);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_inactive("reset");
        end
        rst = 1'b0;
        chk_startup();
        chk_frame(vecs[0].exp, -1, 4'd0);

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            set_digits(vecs[i].d5, vecs[i].d4, vecs[i].d3, vecs[i].d2, vecs[i].d1);
            wait_frame();
            chk_frame(vecs[i].exp, -1, 4'd0);
        end

        // Mid-frame change of dig1 3 -> 7: current frame still shows 3
        set_digits(4'd10, 4'd0, 4'd1, 4'd2, 4'd3);
        wait_frame();
        chk_frame(vecs[0].exp, 1, 4'd7);
        e = vecs[0].exp;
        e[0] = P7;
        chk_frame(e, -1, 4'd0);

        // Reset for one cycle while idx=2, mid-frame
        set_digits(vecs[2].d5, vecs[2].d4, vecs[2].d3, vecs[2].d2, vecs[2].d1);
        wait_frame();
        for (int k = 0; k < 8; k++) step();
        rst = 1'b1;
        step();
        chk_inactive("midrst");
        rst = 1'b0;
        chk_startup();
        chk_frame(vecs[2].exp, -1, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
